// File: rtl/alu_dec_pkg.sv
// -----------------------------------------------------------------------------
// alu_dec_pkg
// Shared definitions for the RV32I -> ALU decode stage:
//   - ALU operation encodings understood by the downstream 32-bit ALU
//   - RV32I major opcodes and the funct7 values the decoder distinguishes
//   - operand-select codes
//   - alu_cmd_t: packed decoded command carried through the stage registers
//   - funct3_alu_op(): funct3 -> ALU op map shared by R-type and I-type
// -----------------------------------------------------------------------------
package alu_dec_pkg;

    localparam int XLEN_MAX = 32;

    // ALU operation encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b0101;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Operand selects
    localparam logic [1:0] OP1_RS1  = 2'b00;
    localparam logic [1:0] OP1_PC   = 2'b01;
    localparam logic [1:0] OP1_ZERO = 2'b10;
    localparam logic       OP2_RS2  = 1'b0;
    localparam logic       OP2_IMM  = 1'b1;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [3:0]          alu_op;
        logic [1:0]          op1_sel;
        logic                op2_sel;
        logic [XLEN_MAX-1:0] imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                illegal;
    } alu_cmd_t;

    // alt selects SUB/SRA over ADD/SRL; funct3 011 (unsigned compare) has no
    // ALU op and falls to ADD, the caller flags it illegal.
    function automatic logic [3:0] funct3_alu_op(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// -----------------------------------------------------------------------------
// alu_decode_stage_if
// Bundles the fetch-side handshake (in_*), the execute-side handshake
// (out_valid/out_ready) and the decoded command payload.
//   modport slave  : the decode stage (consumes in_*, produces out_* payload)
//   modport master : the environment around it (fetch + execute)
// Parameter XLEN: datapath width of pc/imm (only 32 supported).
// -----------------------------------------------------------------------------
interface alu_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [3:0]      alu_op;
    logic [1:0]      op1_sel;
    logic            op2_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, alu_op, op1_sel, op2_sel, imm,
               rs1, rs2, rd, reg_write, mem_read, mem_write, branch, illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, alu_op, op1_sel, op2_sel, imm,
               rs1, rs2, rd, reg_write, mem_read, mem_write, branch, illegal
    );
endinterface

// File: rtl/alu_dec_logic.sv
// -----------------------------------------------------------------------------
// alu_dec_logic
// Purely combinational RV32I instruction -> ALU command decode.
// Ports:
//   instr in 32  - instruction word
//   pc    in 32  - instruction address (passed through into the command)
//   cmd   out    - alu_cmd_t decoded command
// Illegal instructions still produce a command, with illegal=1, alu_op=ADD
// and all control flags cleared.
// -----------------------------------------------------------------------------
module alu_dec_logic
    import alu_dec_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output alu_cmd_t    cmd
);
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd_field;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic        ill;
    logic        writes_rd;

    assign opcode   = instr[6:0];
    assign rd_field = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    always_comb begin
        cmd       = '0;
        ill       = 1'b0;
        writes_rd = 1'b0;

        cmd.pc      = pc;
        cmd.rs1     = instr[19:15];
        cmd.rs2     = instr[24:20];
        cmd.rd      = rd_field;
        cmd.alu_op  = ALU_ADD;
        cmd.op1_sel = OP1_RS1;
        cmd.op2_sel = OP2_RS2;

        case (opcode)
            OPC_OP: begin
                writes_rd  = 1'b1;
                cmd.alu_op = funct3_alu_op(funct3, funct7 == F7_ALT);
                if (funct3 == 3'b011)
                    ill = 1'b1;
                // 0100000 only modifies ADD->SUB and SRL->SRA
                if (!((funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
                    ill = 1'b1;
            end
            OPC_OP_IMM: begin
                writes_rd   = 1'b1;
                cmd.op2_sel = OP2_IMM;
                cmd.imm     = imm_i;
                // ADDI never subtracts; funct7 bits only matter for shifts
                cmd.alu_op  = funct3_alu_op(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
                if (funct3 == 3'b011)
                    ill = 1'b1;
                if ((funct3 == 3'b001) && (funct7 != F7_BASE))
                    ill = 1'b1;
                if ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT))
                    ill = 1'b1;
            end
            OPC_LOAD: begin
                writes_rd    = 1'b1;
                cmd.op2_sel  = OP2_IMM;
                cmd.imm      = imm_i;
                cmd.mem_read = 1'b1;
            end
            OPC_STORE: begin
                cmd.op2_sel   = OP2_IMM;
                cmd.imm       = imm_s;
                cmd.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                cmd.imm    = imm_b;
                cmd.branch = 1'b1;
                case (funct3)
                    3'b000, 3'b001: cmd.alu_op = ALU_SUB;   // BEQ/BNE use the zero flag
                    3'b100, 3'b101: cmd.alu_op = ALU_SLT;   // BLT/BGE
                    default:        ill = 1'b1;             // no unsigned compare
                endcase
            end
            OPC_LUI: begin
                writes_rd   = 1'b1;
                cmd.op1_sel = OP1_ZERO;
                cmd.op2_sel = OP2_IMM;
                cmd.imm     = imm_u;
            end
            OPC_AUIPC: begin
                writes_rd   = 1'b1;
                cmd.op1_sel = OP1_PC;
                cmd.op2_sel = OP2_IMM;
                cmd.imm     = imm_u;
            end
            default: ill = 1'b1;
        endcase

        cmd.reg_write = writes_rd && (rd_field != 5'd0);

        if (ill) begin
            cmd.illegal   = 1'b1;
            cmd.alu_op    = ALU_ADD;
            cmd.reg_write = 1'b0;
            cmd.mem_read  = 1'b0;
            cmd.mem_write = 1'b0;
            cmd.branch    = 1'b0;
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// -----------------------------------------------------------------------------
// alu_decode_stage
// Registered decode stage between fetch and the 32-bit ALU.
// Ports:
//   clk   in  - rising-edge clock
//   reset in  - synchronous, active-high; clears valid bits and payload
//   flush in  - squashes all held entries on the next edge, beats acceptance
//   bus   alu_decode_stage_if.slave - in_* handshake, out_* handshake, payload
// Parameter XLEN: datapath/immediate width (only 32 supported).
// Build option ALU_DEC_SKID_EN: adds a one-entry skid register so in_ready is
// registered (high while the skid entry is empty). Without it, a single output
// register is used and in_ready = !out_valid || out_ready.
// -----------------------------------------------------------------------------
module alu_decode_stage
    import alu_dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    alu_decode_stage_if.slave bus
);
    alu_cmd_t dec_cmd;
    alu_cmd_t out_reg;
    logic     out_valid_reg;
    logic     in_ready;
    logic     accept;

    alu_dec_logic u_dec (
        .instr (bus.in_instr),
        .pc    (bus.in_pc),
        .cmd   (dec_cmd)
    );

    assign accept = bus.in_valid && in_ready;

`ifdef ALU_DEC_SKID_EN
    alu_cmd_t skid_reg;
    logic     skid_valid_reg;
    logic     out_free;

    assign in_ready = !skid_valid_reg;
    assign out_free = !out_valid_reg || bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_reg        <= '0;
            skid_valid_reg <= 1'b0;
            skid_reg       <= '0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (out_free) begin
            // Older skid entry drains first; acceptance is impossible while
            // skid is full, so order is preserved.
            if (skid_valid_reg) begin
                out_reg        <= skid_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (accept) begin
                out_reg       <= dec_cmd;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            skid_reg       <= dec_cmd;
            skid_valid_reg <= 1'b1;
        end
    end
`else
    assign in_ready = !out_valid_reg || bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            // Covers the consume-and-accept case: replace with no bubble.
            out_reg       <= dec_cmd;
            out_valid_reg <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_pc    = out_reg.pc[XLEN-1:0];
    assign bus.alu_op    = out_reg.alu_op;
    assign bus.op1_sel   = out_reg.op1_sel;
    assign bus.op2_sel   = out_reg.op2_sel;
    assign bus.imm       = out_reg.imm[XLEN-1:0];
    assign bus.rs1       = out_reg.rs1;
    assign bus.rs2       = out_reg.rs2;
    assign bus.rd        = out_reg.rd;
    assign bus.reg_write = out_reg.reg_write;
    assign bus.mem_read  = out_reg.mem_read;
    assign bus.mem_write = out_reg.mem_write;
    assign bus.branch    = out_reg.branch;
    assign bus.illegal   = out_reg.illegal;

endmodule
